// File: rtl/simd_lane_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module   : simd_lane_dispatch_if
//  Brief    : Control, BRAM port B and PE-lane bundle of the SIMD lane dispatcher
//  Revision : 1.0  initial release
// ============================================================================
interface simd_lane_dispatch_if #(
    parameter int NUM_PE = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int LEN_W  = 8
);
    logic                     START;
    logic                     MODE;
    logic [ADDR_W-1:0]        BASE_ADDR;
    logic [LEN_W-1:0]         LEN;
    logic [NUM_PE-1:0]        LANE_MASK;
    logic                     ABORT;
    logic                     BUSY;
    logic                     DONE;
    logic                     ERR;
    logic [ADDR_W-1:0]        addrb;
    logic [DATA_W-1:0]        dinb;
    logic [DATA_W-1:0]        doutb;
    logic                     enb;
    logic [DATA_W/8-1:0]      web;
    logic [NUM_PE*DATA_W-1:0] PE_DIN;
    logic [NUM_PE-1:0]        PE_WR;
    logic [NUM_PE*DATA_W-1:0] PE_DOUT;
    logic [NUM_PE-1:0]        PE_RD;
    logic [NUM_PE-1:0]        PE_DONE;
    logic                     ALL_DONE;

    modport master (
        input  START, MODE, BASE_ADDR, LEN, LANE_MASK, ABORT, doutb, PE_DOUT, PE_DONE,
        output BUSY, DONE, ERR, addrb, dinb, enb, web, PE_DIN, PE_WR, PE_RD, ALL_DONE
    );

    modport slave (
        output START, MODE, BASE_ADDR, LEN, LANE_MASK, ABORT, doutb, PE_DOUT, PE_DONE,
        input  BUSY, DONE, ERR, addrb, dinb, enb, web, PE_DIN, PE_WR, PE_RD, ALL_DONE
    );
endinterface
`default_nettype wire

// File: rtl/simd_lane_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : simd_lane_dispatch
//  Brief    : BRAM <-> PE-array mover, round-robin over the enabled lanes
//  Revision : 1.0  initial release
// ============================================================================
module simd_lane_dispatch #(
    parameter int NUM_PE   = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 13,
    parameter int LEN_W    = 8,
    parameter int BRAM_LAT = 2
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    simd_lane_dispatch_if.master bus
);
    localparam int PC_W   = $clog2(NUM_PE + 1);
    localparam int CNT_W  = LEN_W + PC_W;
    localparam int SUM_W  = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;
    localparam int LANE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_ISSUE = 3'd1,
        S_LOAD_DRAIN = 3'd2,
        S_STORE      = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_PE-1:0] m);
        popcount = '0;
        for (int k = 0; k < NUM_PE; k++) popcount = popcount + PC_W'(m[k]);
    endfunction

    function automatic logic [LANE_W-1:0] first_lane(input logic [NUM_PE-1:0] m);
        first_lane = '0;
        for (int k = NUM_PE - 1; k >= 0; k--) if (m[k]) first_lane = LANE_W'(k);
    endfunction

    // Descending offsets so the nearest enabled lane after cur wins.
    function automatic logic [LANE_W-1:0] next_lane(input logic [NUM_PE-1:0] m,
                                                    input logic [LANE_W-1:0] cur);
        int idx;
        next_lane = cur;
        for (int k = NUM_PE; k >= 1; k--) begin
            idx = (int'(cur) + k) % NUM_PE;
            if (m[idx]) next_lane = LANE_W'(idx);
        end
    endfunction

    function automatic logic [NUM_PE-1:0] onehot(input logic [LANE_W-1:0] l);
        onehot = NUM_PE'(1) << l;
    endfunction

    state_t                   r_state;
    logic                     r_mode;
    logic [NUM_PE-1:0]        r_mask;
    logic [CNT_W-1:0]         r_total;
    logic [CNT_W-1:0]         r_cnt;
    logic [LANE_W-1:0]        r_lane;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;
    logic [ADDR_W-1:0]        r_addr;
    logic                     r_enb;
    logic [BE_W-1:0]          r_web;
    logic [NUM_PE*DATA_W-1:0] r_pe_din;
    logic [NUM_PE-1:0]        r_pe_wr;
    logic [NUM_PE-1:0]        r_pe_rd;
    logic                     r_all_done;
    logic [BRAM_LAT-1:0]      r_pv;
    logic [LANE_W-1:0]        r_pt [BRAM_LAT];

    logic [PC_W-1:0]   w_nact;
    logic [CNT_W-1:0]  w_total;
    logic [SUM_W-1:0]  w_end;
    logic              w_reject;
    logic              w_abort;
    logic [LANE_W-1:0] w_first;
    logic [LANE_W-1:0] w_next;

    assign w_nact   = popcount(bus.LANE_MASK);
    assign w_total  = CNT_W'(bus.LEN) * CNT_W'(w_nact);
    // BASE+T-1 > 2^ADDR_W-1 rewritten as BASE+T > 2^ADDR_W to stay unsigned
    assign w_end    = SUM_W'(bus.BASE_ADDR) + SUM_W'(w_total);
    assign w_reject = (bus.LEN == '0) || (bus.LANE_MASK == '0) ||
                      (w_end > (SUM_W'(1) << ADDR_W));
    assign w_abort  = bus.ABORT && ((r_state == S_LOAD_ISSUE) ||
                                    (r_state == S_LOAD_DRAIN) ||
                                    (r_state == S_STORE));
    assign w_first  = first_lane(bus.LANE_MASK);
    assign w_next   = next_lane(r_mask, r_lane);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_mask     <= '0;
            r_total    <= '0;
            r_cnt      <= '0;
            r_lane     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_enb      <= 1'b0;
            r_web      <= '0;
            r_pe_din   <= '0;
            r_pe_wr    <= '0;
            r_pe_rd    <= '0;
            r_all_done <= 1'b0;
            r_pv       <= '0;
            for (int k = 0; k < BRAM_LAT; k++) r_pt[k] <= '0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_all_done <= (|r_mask) & (&(bus.PE_DONE | ~r_mask));

            // Lane tag rides alongside each load read until doutb is valid
            r_pv[0] <= r_enb & ~r_mode;
            r_pt[0] <= r_lane;
            for (int k = BRAM_LAT - 1; k > 0; k--) begin
                r_pv[k] <= r_pv[k-1];
                r_pt[k] <= r_pt[k-1];
            end
            r_pe_wr <= '0;
            if (r_pv[BRAM_LAT-1] && !w_abort) begin
                r_pe_wr <= onehot(r_pt[BRAM_LAT-1]);
                r_pe_din[r_pt[BRAM_LAT-1]*DATA_W +: DATA_W] <= bus.doutb;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_busy <= 1'b1;
                        if (w_reject) begin
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_mode  <= bus.MODE;
                            r_mask  <= bus.LANE_MASK;
                            r_total <= w_total;
                            r_cnt   <= CNT_W'(1);
                            r_lane  <= w_first;
                            r_addr  <= bus.BASE_ADDR;
                            r_enb   <= 1'b1;
                            r_web   <= bus.MODE ? {BE_W{1'b1}} : '0;
                            r_pe_rd <= bus.MODE ? onehot(w_first) : '0;
                            r_state <= bus.MODE ? S_STORE : S_LOAD_ISSUE;
                        end
                    end
                end
                S_LOAD_ISSUE: begin
                    if (r_cnt == r_total) begin
                        r_enb   <= 1'b0;
                        r_state <= S_LOAD_DRAIN;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_lane <= w_next;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                S_LOAD_DRAIN: begin
                    if (r_pv == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_STORE: begin
                    if (r_cnt == r_total) begin
                        r_enb   <= 1'b0;
                        r_web   <= '0;
                        r_pe_rd <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_lane  <= w_next;
                        r_pe_rd <= onehot(w_next);
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_err   <= 1'b1;
                r_enb   <= 1'b0;
                r_web   <= '0;
                r_pe_rd <= '0;
                r_pe_wr <= '0;
                r_pv    <= '0;
            end
        end
    end

    assign bus.BUSY     = r_busy;
    assign bus.DONE     = r_done;
    assign bus.ERR      = r_err;
    assign bus.addrb    = r_addr;
    assign bus.enb      = r_enb;
    assign bus.web      = r_web;
    // Write data only driven while a store beat is on the port
    assign bus.dinb     = r_web[0] ? bus.PE_DOUT[r_lane*DATA_W +: DATA_W] : '0;
    assign bus.PE_DIN   = r_pe_din;
    assign bus.PE_WR    = r_pe_wr;
    assign bus.PE_RD    = r_pe_rd;
    assign bus.ALL_DONE = r_all_done;

endmodule
`default_nettype wire

// File: tb/tb_simd_lane_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simd_lane_dispatch
//  Brief    : Scoreboard bench: driver predicts bus events, monitor pops/compares
//  Revision : 1.0  initial release
// ============================================================================
module tb_simd_lane_dispatch;
    localparam int NUM_PE = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;
    localparam int LEN_W  = 8;
    localparam int LAT    = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    simd_lane_dispatch_if #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    simd_lane_dispatch #(
        .NUM_PE(NUM_PE), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BRAM_LAT(LAT)
    ) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus)
    );

    typedef struct { int c; logic [12:0] addr; logic we; logic [31:0] data; logic [3:0] rd; } bram_ev_t;
    typedef struct { int c; int lane; logic [31:0] data; } wr_ev_t;
    typedef struct { int c; logic done; logic err; } end_ev_t;

    bram_ev_t q_bram[$];
    wr_ev_t   q_wr[$];
    end_ev_t  q_end[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_lo = 1;
    int busy_hi = 0;
    bit mon_en  = 1'b1;

    logic [31:0] mem [8192];
    logic [31:0] pe_val [NUM_PE];
    logic [12:0] dl [LAT];

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM read model: data for the address presented LAT cycles earlier
    always @(posedge clk) begin
        dl[0] <= bus.addrb;
        for (int k = 1; k < LAT; k++) dl[k] <= dl[k-1];
    end
    assign bus.doutb = mem[dl[LAT-1]];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    bram_ev_t mb;
    wr_ev_t   mw;
    end_ev_t  me;

    always @(negedge clk) begin
        if (rstn && mon_en) begin
            check("busy", 64'(bus.BUSY), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
            if (bus.enb) begin
                if (q_bram.size() == 0) check("bram_unexpected", 64'(bus.addrb), 64'hFFFF_FFFF);
                else begin
                    mb = q_bram.pop_front();
                    check("bram_cycle", 64'(cyc), 64'(mb.c));
                    check("addrb", 64'(bus.addrb), 64'(mb.addr));
                    check("web", 64'(bus.web), mb.we ? 64'hF : 64'h0);
                    if (mb.we) check("dinb", 64'(bus.dinb), 64'(mb.data));
                    check("pe_rd", 64'(bus.PE_RD), 64'(mb.rd));
                end
            end else if (bus.PE_RD != 0) check("pe_rd_idle", 64'(bus.PE_RD), 64'h0);
            if (bus.PE_WR != 0) begin
                if (q_wr.size() == 0) check("pe_wr_unexpected", 64'(bus.PE_WR), 64'h0);
                else begin
                    mw = q_wr.pop_front();
                    check("pe_wr_cycle", 64'(cyc), 64'(mw.c));
                    check("pe_wr", 64'(bus.PE_WR), 64'(1) << mw.lane);
                    check("pe_din", 64'(bus.PE_DIN[mw.lane*DATA_W +: DATA_W]), 64'(mw.data));
                end
            end
            if (bus.DONE || bus.ERR) begin
                if (q_end.size() == 0) check("end_unexpected", 64'({bus.DONE, bus.ERR}), 64'h0);
                else begin
                    me = q_end.pop_front();
                    check("end_cycle", 64'(cyc), 64'(me.c));
                    check("done", 64'(bus.DONE), 64'(me.done));
                    check("err", 64'(bus.ERR), 64'(me.err));
                end
            end
        end
    end

    task automatic drive_pe_dout();
        for (int i = 0; i < NUM_PE; i++) bus.PE_DOUT[i*DATA_W +: DATA_W] = pe_val[i];
    endtask

    // abort_req: 0 none, -1 random, >0 abort raised in that cycle of the op
    task automatic run_op(input logic mode, input int base, input int len, input logic [3:0] mask,
                          input int abort_req, input bit start_again);
        int lanes[$];
        int nact, t, endrel, c0, a, lane;
        bit rej;
        for (int i = 0; i < NUM_PE; i++) if (mask[i]) lanes.push_back(i);
        nact   = lanes.size();
        t      = len * nact;
        rej    = (len == 0) || (nact == 0) || (base + t - 1 > 8191);
        endrel = rej ? 1 : (mode ? t + 1 : t + 2 + LAT);
        a = 0;
        if (!rej && abort_req > 0 && abort_req < endrel) a = abort_req;
        if (!rej && abort_req < 0 && endrel >= 2) a = $urandom_range(1, endrel - 1);

        @(posedge clk); #1;
        drive_pe_dout();
        bus.START = 1'b1; bus.MODE = mode; bus.BASE_ADDR = base[12:0];
        bus.LEN = len[7:0]; bus.LANE_MASK = mask;
        c0 = cyc;
        busy_lo = c0 + 1;
        busy_hi = (a > 0) ? c0 + a : c0 + endrel;
        if (!rej) begin
            for (int i = 0; i < t; i++) begin
                bram_ev_t be;
                wr_ev_t   we;
                lane = lanes[i % nact];
                if (a == 0 || 1 + i <= a) begin
                    be.c = c0 + 1 + i; be.addr = 13'(base + i); be.we = mode;
                    be.data = pe_val[lane]; be.rd = mode ? 4'(1 << lane) : 4'h0;
                    q_bram.push_back(be);
                end
                if (!mode && (a == 0 || 2 + i + LAT <= a)) begin
                    we.c = c0 + 2 + i + LAT; we.lane = lane; we.data = mem[base + i];
                    q_wr.push_back(we);
                end
            end
        end
        begin
            end_ev_t ee;
            if (a > 0) begin ee.c = c0 + a + 1; ee.done = 1'b0; ee.err = 1'b1; end
            else begin ee.c = c0 + endrel; ee.done = 1'b1; ee.err = rej; end
            q_end.push_back(ee);
        end

        @(posedge clk); #1;
        bus.START = 1'b0;
        bus.MODE = 1'($urandom); bus.BASE_ADDR = 13'($urandom);
        bus.LEN = 8'($urandom); bus.LANE_MASK = 4'($urandom);
        for (int n = 0; n < 300 && !(q_end.size() == 0 && cyc > busy_hi + 1); n++) begin
            bus.ABORT = (a > 0) && (cyc == c0 + a);
            bus.START = start_again && (cyc == c0 + 2) && (busy_hi >= c0 + 2);
            @(posedge clk); #1;
        end
        bus.ABORT = 1'b0;
        bus.START = 1'b0;
        check("op_timeout", 64'(q_end.size()), 64'h0);
        check("left_bram", 64'(q_bram.size()), 64'h0);
        check("left_wr", 64'(q_wr.size()), 64'h0);
        q_bram.delete(); q_wr.delete(); q_end.delete();
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_ctrl"}, 64'({bus.BUSY, bus.DONE, bus.ERR, bus.enb, bus.web, bus.addrb,
                                  bus.PE_WR, bus.PE_RD, bus.ALL_DONE}), 64'h0);
        check({nm, "_dinb"}, 64'(bus.dinb), 64'h0);
        check({nm, "_pe_din"}, 64'(|bus.PE_DIN), 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.START = 0; bus.MODE = 0; bus.BASE_ADDR = 0; bus.LEN = 0; bus.LANE_MASK = 0;
        bus.ABORT = 0; bus.PE_DOUT = '0; bus.PE_DONE = 4'hF;
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        for (int i = 0; i < NUM_PE; i++) pe_val[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("all_done_mask0", 64'(bus.ALL_DONE), 64'h0);

        // Load 1111 LEN=2, BRAM word k = 0xA0+k
        for (int k = 0; k < 8; k++) mem[16 + k] = 32'hA0 + k;
        run_op(1'b0, 16'h010, 2, 4'b1111, 0, 1'b0);
        run_op(1'b0, 16'h100, 3, 4'b0101, 0, 1'b0);
        for (int i = 0; i < NUM_PE; i++) pe_val[i] = 32'hB0 + i;
        run_op(1'b1, 16'h020, 2, 4'b1011, 0, 1'b0);
        run_op(1'b0, 16'h1FFE, 1, 4'b1111, 0, 1'b0);
        run_op(1'b0, 16'h1FFC, 1, 4'b1111, 0, 1'b0);
        run_op(1'b1, 16'h1FFC, 1, 4'b1111, 0, 1'b0);
        run_op(1'b0, 16'h050, 0, 4'b1111, 0, 1'b0);
        run_op(1'b1, 16'h050, 2, 4'b0000, 0, 1'b0);
        run_op(1'b0, 16'h300, 2, 4'b1111, 3, 1'b0);
        run_op(1'b1, 16'h340, 3, 4'b1101, 2, 1'b0);
        run_op(1'b0, 16'h400, 2, 4'b1001, 0, 1'b1);
        run_op(1'b1, 16'h440, 2, 4'b0110, 0, 1'b1);

        // ALL_DONE against the mask latched by the last accepted op (0110)
        bus.PE_DONE = 4'b0110;
        repeat (2) @(posedge clk);
        #1;
        check("all_done_0110", 64'(bus.ALL_DONE), 64'h1);
        bus.PE_DONE = 4'b0100;
        repeat (2) @(posedge clk);
        #1;
        check("all_done_0100", 64'(bus.ALL_DONE), 64'h0);
        bus.PE_DONE = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("all_done_1111", 64'(bus.ALL_DONE), 64'h1);

        for (int n = 0; n < 40; n++) begin
            logic mode;
            int   base, len;
            logic [3:0] mask;
            mode = 1'($urandom_range(0, 1));
            mask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            len  = $urandom_range(0, 5);
            base = ($urandom_range(0, 3) == 0) ? 8192 - $urandom_range(1, 24) : $urandom_range(0, 8191);
            for (int i = 0; i < NUM_PE; i++) pe_val[i] = $urandom;
            bus.PE_DONE = 4'($urandom);
            run_op(mode, base, len, mask, ($urandom_range(0, 4) == 0) ? -1 : 0,
                   1'($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a store
        mon_en = 1'b0;
        for (int i = 0; i < NUM_PE; i++) pe_val[i] = 32'hC0DE_0000 + i;
        drive_pe_dout();
        @(posedge clk); #1;
        bus.START = 1'b1; bus.MODE = 1'b1; bus.BASE_ADDR = 13'h600; bus.LEN = 8'd4; bus.LANE_MASK = 4'hF;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_store_enb", 64'(bus.enb), 64'h1);
        rstn = 1'b0;
        #1;
        check_all_zero("async_reset");
        busy_lo = 1; busy_hi = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_busy", 64'(bus.BUSY), 64'h0);
        mon_en = 1'b1;
        run_op(1'b0, 16'h700, 2, 4'b0011, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
